// File: rtl/fc_act_loader.sv
// fc_act_loader: assembles IN streamed activations into the parallel x bus
// Ports: s_* beat stream in, x/x_valid/x_ready vector out, err_len pulse; FC_ACT_LOADER_DBUF_EN adds a second bank
module fc_act_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             err_len
);

  localparam int IW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);

  logic [IW-1:0] idx_q, idx_d;
  logic          s_ready_q, s_ready_d;
  logic          x_valid_q, x_valid_d;
  logic          err_len_q, err_len_d;
  logic          accept;
  logic          done;

  assign accept  = s_valid && s_ready_q;
  assign done    = accept && (idx_q == LAST_IDX);
  assign s_ready = s_ready_q;
  assign x_valid = x_valid_q;
  assign err_len = err_len_q;

  // A full-length vector always completes; an early last drops the partial one.
  always_comb begin
    idx_d     = idx_q;
    err_len_d = 1'b0;
    if (accept) begin
      if (idx_q == LAST_IDX) begin
        idx_d     = '0;
        err_len_d = !s_last;
      end else if (s_last) begin
        idx_d     = '0;
        err_len_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

`ifdef FC_ACT_LOADER_DBUF_EN
  logic [WIDTH-1:0] mem_q [2][IN];
  logic [WIDTH-1:0] mem_d [2][IN];
  logic             hb_q, hb_d;
  logic             held_q, held_d;
  logic             full_q, full_d;
  logic             release_x;

  assign release_x = held_q && x_ready;

  // hb_q selects the bank on x; the other bank is always the fill bank.
  always_comb begin
    hb_d   = hb_q;
    held_d = held_q;
    full_d = full_q;
    if (done && (!held_q || release_x)) begin
      hb_d   = ~hb_q;
      held_d = 1'b1;
    end else if (done) begin
      full_d = 1'b1;
    end else if (release_x && full_q) begin
      hb_d   = ~hb_q;
      full_d = 1'b0;
    end else if (release_x) begin
      held_d = 1'b0;
    end
    s_ready_d = !full_d;
    x_valid_d = held_d;
  end

  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[~hb_q][idx_q] = s_data;
  end

  always_comb begin
    for (int i = 0; i < IN; i++) x[i] = mem_q[hb_q][i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q   <= 1'b0;
      held_q <= 1'b0;
      full_q <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < IN; i++) mem_q[b][i] <= '0;
    end else begin
      hb_q   <= hb_d;
      held_q <= held_d;
      full_q <= full_d;
      mem_q  <= mem_d;
    end
  end
`else
  typedef enum logic {FILL, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_q [IN];
  logic [WIDTH-1:0] mem_d [IN];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (done) state_d = HOLD;
      HOLD: if (x_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
    s_ready_d = (state_d == FILL);
    x_valid_d = (state_d == HOLD);
  end

  // Writes only happen while s_ready is high, so x is frozen in HOLD.
  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[idx_q] = s_data;
  end

  always_comb begin
    for (int i = 0; i < IN; i++) x[i] = mem_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      for (int i = 0; i < IN; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      s_ready_q <= 1'b0;
      x_valid_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      s_ready_q <= s_ready_d;
      x_valid_q <= x_valid_d;
      err_len_q <= err_len_d;
    end
  end

endmodule

// File: tb/tb_fc_act_loader.sv
// tb_fc_act_loader: directed bench for fc_act_loader
// Drives beats #1 after each rising edge and samples there too
module tb_fc_act_loader;

  localparam int WIDTH = 8;
  localparam int IN    = 128;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             x_valid;
  logic             x_ready;
  logic             err_len;

  int checks = 0;
  int errors = 0;
  int errs_seen;

  fc_act_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .err_len (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k, input int i);
    int t;
    case (k)
      0:       t = i;
      1:       t = 'hA5;
      2:       t = i * 3;
      3:       t = ~i;
      4:       t = 'h11;
      default: t = 0;
    endcase
    return t[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input int first, input int n,
                      input int last_at);
    for (int b = first; b < first + n; b++) begin
      s_valid = 1'b1;
      s_data  = pat(k, b);
      s_last  = (b == last_at);
      tick();
      if (err_len) errs_seen++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic vec_ok(input int k, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < IN; i++)
      if (x[i] !== pat(k, i)) bad++;
    check(tag, bad, 0);
  endtask

  task automatic release_x();
    x_ready = 1'b1;
    tick();
    x_ready = 1'b0;
    check("rel_xv", x_valid, 0);
    check("rel_srdy", s_ready, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    x_ready = 1'b0;
    #12;
    check("rst_srdy", s_ready, 0);
    check("rst_xv", x_valid, 0);
    check("rst_err", err_len, 0);
    vec_ok(5, "rst_x");
    tick();
    rst_n = 1'b1;
    check("pre_srdy", s_ready, 0);
    tick();
    check("up_srdy", s_ready, 1);

`ifdef FC_ACT_LOADER_DBUF_EN
    begin
      int sr_drop;
      int xv_drop;
      sr_drop = 0;
      xv_drop = 0;
      for (int v = 0; v < 3; v++) begin
        for (int b = 0; b < IN; b++) begin
          s_valid = 1'b1;
          s_data  = pat(v, b);
          s_last  = (b == IN - 1);
          x_ready = (v > 0) && (b == IN - 1);
          tick();
          if (!s_ready) sr_drop++;
          if (v > 0 && !x_valid) xv_drop++;
        end
        check("db_xv", x_valid, 1);
        vec_ok(v, "db_vec");
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      x_ready = 1'b0;
      check("db_srdy_drop", sr_drop, 0);
      check("db_xv_drop", xv_drop, 0);
    end
`else
    errs_seen = 0;
    send(0, 0, IN - 1, IN - 1);
    check("fill_xv_early", x_valid, 0);
    check("fill_srdy_early", s_ready, 1);
    send(0, IN - 1, 1, IN - 1);
    check("fill_xv", x_valid, 1);
    check("fill_srdy", s_ready, 0);
    check("fill_err", errs_seen, 0);
    vec_ok(0, "fill_vec");

    s_valid = 1'b1;
    s_data  = 8'hFF;
    repeat (50) tick();
    s_valid = 1'b0;
    check("hold_xv", x_valid, 1);
    check("hold_srdy", s_ready, 0);
    vec_ok(0, "hold_vec");
    release_x();

    send(4, 0, 11, 10);
    check("early_err", err_len, 1);
    check("early_xv", x_valid, 0);
    check("early_srdy", s_ready, 1);
    errs_seen = 0;
    send(1, 0, IN, IN - 1);
    check("early_err_once", errs_seen, 0);
    check("early_next_xv", x_valid, 1);
    vec_ok(1, "early_next_vec");
    release_x();

    errs_seen = 0;
    send(2, 0, IN, -1);
    check("miss_err", err_len, 1);
    check("miss_xv", x_valid, 1);
    vec_ok(2, "miss_vec");
    release_x();
    check("miss_err_drop", err_len, 0);

    send(3, 0, 60, -1);
    rst_n = 1'b0;
    #1;
    check("mrst_xv", x_valid, 0);
    check("mrst_srdy", s_ready, 0);
    vec_ok(5, "mrst_x");
    tick();
    rst_n = 1'b1;
    tick();
    check("mrst_up", s_ready, 1);
    x_ready = 1'b1;
    send(3, 0, IN, IN - 1);
    check("mrst_xv_full", x_valid, 1);
    vec_ok(3, "mrst_vec");
    tick();
    x_ready = 1'b0;
    check("mrst_rel", x_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
